// File: rtl/piso_reg_n_bits_pkg.sv
// Shared state encoding for the PISO serialiser and its bit counter.
// The PAR state is only reachable when the design is built with PARITY_EN.
package piso_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_PAR   = ST_PAR
  } state_e;

endpackage

// File: rtl/piso_reg_n_bits_bit_counter.sv
// Up-counter with synchronous clear and enable, flagging terminal count at size-1.
// Width is $clog2(size+1) so the count never wraps inside a frame.
module bit_counter #(
  parameter int size = 8,
  parameter int CW   = $clog2(size + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(size - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable so a new frame always starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/piso_reg_n_bits.sv
// Parallel-in serial-out register: captures Din on load and shifts it out LSB first.
// Optional feature macro PARITY_EN appends one even-parity bit to every frame.
module piso_reg_n_bits
  import piso_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [size-1:0] Din,
  input  logic            load,
  output logic            ready,
  output logic            sout,
  output logic            sout_valid,
  output logic            done
);

  state_e          state_q;
  logic [size-1:0] shreg_q;
  logic [size-1:0] shifted;
  logic            sout_q;
  logic            valid_q;
  logic            done_q;
  logic            ready_q;
  logic            cnt_clear;
  logic            cnt_en;
  logic            last_bit;
`ifdef PARITY_EN
  logic            parity_q;
`endif

  assign shifted   = shreg_q >> 1;
  assign cnt_clear = (state_q == S_IDLE) && load;
  assign cnt_en    = (state_q == S_SHIFT);

  bit_counter #(
    .size(size)
  ) u_bit_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (last_bit)
  );

  // Outputs are registered alongside the state: each branch sets what the next cycle presents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (load) begin
            state_q  <= S_SHIFT;
            shreg_q  <= Din;
            sout_q   <= Din[0];
            valid_q  <= 1'b1;
            ready_q  <= 1'b0;
`ifdef PARITY_EN
            parity_q <= ^Din;
`endif
          end else begin
            sout_q   <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
          end
        end

        S_SHIFT: begin
          shreg_q <= shifted;
          if (last_bit) begin
`ifdef PARITY_EN
            state_q <= S_PAR;
            sout_q  <= parity_q;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
`else
            state_q <= S_IDLE;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
`endif
          end else begin
            sout_q  <= shifted[0];
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end

`ifdef PARITY_EN
        S_PAR: begin
          state_q <= S_IDLE;
          sout_q  <= 1'b0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
`endif

        default: begin
          state_q <= S_IDLE;
          sout_q  <= 1'b0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_reg_n_bits.sv
// Directed bench for piso_reg_n_bits (size=8 and size=1 instances).
// Expected frames include the parity bit when built with PARITY_EN.
module tb_piso_reg_n_bits;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       load;
  logic       ready, sout, soutValid, done;
  logic [0:0] din1;
  logic       load1;
  logic       ready1, sout1, soutValid1, done1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic       expReady;
    logic       expSout;
    logic       expValid;
    logic       expDone;
    string      name;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  piso_reg_n_bits #(.size(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .Din       (din),
    .load      (load),
    .ready     (ready),
    .sout      (sout),
    .sout_valid(soutValid),
    .done      (done)
  );

  piso_reg_n_bits #(.size(1)) dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .Din       (din1),
    .load      (load1),
    .ready     (ready1),
    .sout      (sout1),
    .sout_valid(soutValid1),
    .done      (done1)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic ld, input logic [7:0] d, input logic r,
                                 input logic s, input logic v, input logic dn, input string nm);
    vec_t x;
    x.ld = ld; x.d = d; x.expReady = r; x.expSout = s; x.expValid = v; x.expDone = dn;
    x.name = nm;
    vecs.push_back(x);
  endfunction

  // One frame: load row, remaining data bits (with given mid-frame inputs), optional parity, done row.
  function automatic void addFrame(input string tag, input logic [7:0] d,
                                   input logic ldRest, input logic [7:0] dRest);
    addVec(1'b1, d, 1'b0, d[0], 1'b1, 1'b0, $sformatf("%s bit0", tag));
    for (int i = 1; i < 8; i++)
      addVec(ldRest, dRest, 1'b0, d[i], 1'b1, 1'b0, $sformatf("%s bit%0d", tag, i));
`ifdef PARITY_EN
    addVec(ldRest, dRest, 1'b0, ^d, 1'b1, 1'b0, $sformatf("%s parity", tag));
`endif
    addVec(ldRest, dRest, 1'b1, 1'b0, 1'b0, 1'b1, $sformatf("%s done", tag));
  endfunction

  task automatic checkAll(input string nm, input logic r, input logic s, input logic v,
                          input logic dn);
    checkOutput({nm, " ready"}, ready, r);
    checkOutput({nm, " sout"}, sout, s);
    checkOutput({nm, " valid"}, soutValid, v);
    checkOutput({nm, " done"}, done, dn);
  endtask

  task automatic applyStimulus();
    foreach (vecs[j]) begin
      load = vecs[j].ld;
      din  = vecs[j].d;
      @(negedge clock);
      checkAll(vecs[j].name, vecs[j].expReady, vecs[j].expSout, vecs[j].expValid,
               vecs[j].expDone);
    end
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    din     = 8'h00;
    load1   = 1'b0;
    din1    = 1'b0;

    addFrame("ff", 8'hff, 1'b0, 8'hff);
    addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "idle after ff");
    addFrame("f0", 8'hf0, 1'b0, 8'hf0);
    addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "idle after f0");
    addFrame("a5", 8'ha5, 1'b1, 8'h3c);
    addFrame("3c", 8'h3c, 1'b0, 8'h3c);
    addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "idle after 3c");
    addFrame("ff din00", 8'hff, 1'b0, 8'h00);
    addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "idle after ff din00");
    addFrame("07", 8'h07, 1'b0, 8'h00);
    addVec(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "idle after 07");

    repeat (3) @(negedge clock);
    checkAll("in reset", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("in reset ready1", ready1, 1'b1);
    reset_n = 1'b1;
    @(negedge clock);
    checkAll("after reset", 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus();

    // Abort a frame with reset while bit 3 is on the line.
    load = 1'b1;
    din  = 8'hff;
    @(negedge clock);
    load = 1'b0;
    repeat (3) @(negedge clock);
    checkAll("abort bit3", 1'b0, 1'b1, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 checkAll("abort async", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkAll("abort release", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) begin
      @(negedge clock);
      checkOutput("abort no done", done, 1'b0);
    end

    // One-bit instance.
    load1 = 1'b1;
    din1  = 1'b1;
    @(negedge clock);
    load1 = 1'b0;
    checkOutput("size1 d1 sout", sout1, 1'b1);
    checkOutput("size1 d1 valid", soutValid1, 1'b1);
    checkOutput("size1 d1 ready", ready1, 1'b0);
`ifdef PARITY_EN
    @(negedge clock);
    checkOutput("size1 d1 parity", sout1, 1'b1);
    checkOutput("size1 d1 parity valid", soutValid1, 1'b1);
`endif
    @(negedge clock);
    checkOutput("size1 d1 done", done1, 1'b1);
    checkOutput("size1 d1 done ready", ready1, 1'b1);
    checkOutput("size1 d1 done valid", soutValid1, 1'b0);
    @(negedge clock);
    checkOutput("size1 d1 done clear", done1, 1'b0);
    load1 = 1'b1;
    din1  = 1'b0;
    @(negedge clock);
    load1 = 1'b0;
    checkOutput("size1 d0 sout", sout1, 1'b0);
    checkOutput("size1 d0 valid", soutValid1, 1'b1);
`ifdef PARITY_EN
    @(negedge clock);
    checkOutput("size1 d0 parity", sout1, 1'b0);
`endif
    @(negedge clock);
    checkOutput("size1 d0 done", done1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
